// File: rtl/wb_sram_slave.sv
// Wishbone classic responder in front of a byte-writable 32-bit RAM.
// Each request waits WAIT_STATES cycles, then one access and a one-cycle ack.
module wb_sram_slave #(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [29:0] adr_i,
  input  logic [31:0] dat_i,
  input  logic [3:0]  sel_i,
  input  logic        we_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  output logic [31:0] dat_o,
  output logic        ack_o
);

  localparam int         DEPTH = 1 << ADDR_BITS;
  localparam logic [3:0] WS_C  = 4'(WAIT_STATES);

  // Handshake: a request is valid while cyc_i & stb_i; ack_o pulses once per
  // completed transfer; dropping the request before the access aborts it.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [29:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d;
  logic        ack_q, ack_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] mem_q [0:DEPTH-1];

  logic                 req;
  logic                 acc_go;
  logic                 use_in;
  logic [29:0]          acc_adr;
  logic [31:0]          acc_dat;
  logic [3:0]           acc_sel;
  logic                 acc_we;
  logic                 acc_in_range;
  logic [ADDR_BITS-1:0] acc_idx;
  logic                 mem_wr;

  assign req = cyc_i & stb_i;

  // With zero wait states the access happens on the capture edge itself,
  // so the operands come straight from the bus instead of the latches.
  assign use_in       = (state_q == ST_IDLE);
  assign acc_adr      = use_in ? adr_i : adr_q;
  assign acc_dat      = use_in ? dat_i : dat_q;
  assign acc_sel      = use_in ? sel_i : sel_q;
  assign acc_we       = use_in ? we_i  : we_q;
  assign acc_in_range = ((acc_adr >> ADDR_BITS) == 30'd0);
  assign acc_idx      = acc_adr[ADDR_BITS-1:0];
  assign mem_wr       = acc_go & acc_we & acc_in_range & ~rst_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    ack_d   = 1'b0;
    rdata_d = rdata_q;
    acc_go  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          adr_d = adr_i;
          dat_d = dat_i;
          sel_d = sel_i;
          we_d  = we_i;
          cnt_d = WS_C;
          if (WS_C == 4'd0) begin
            acc_go  = 1'b1;
            state_d = ST_ACK;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!req) begin
          cnt_d   = 4'd0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            acc_go  = 1'b1;
            state_d = ST_ACK;
          end
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (acc_go) begin
      ack_d = 1'b1;
      if (!acc_we) begin
        rdata_d = acc_in_range ? mem_q[acc_idx] : 32'h0000_0000;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      adr_q   <= 30'd0;
      dat_q   <= 32'd0;
      sel_q   <= 4'd0;
      we_q    <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  // RAM contents survive reset; mem_wr is gated so a reset edge never writes.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_wr && acc_sel[b]) begin
        mem_q[acc_idx][8*b +: 8] <= acc_dat[8*b +: 8];
      end
    end
  end

  assign dat_o = rdata_q;
  assign ack_o = ack_q;

endmodule

// File: tb/tb_wb_sram_slave.sv
// Bench for wb_sram_slave: three instances (0, 1 and 3 wait states), a
// transaction-level model, a per-cycle compare process and directed checks.
module tb_wb_sram_slave;

  localparam int AB = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [29:0] adr [3];
  logic [31:0] dat [3];
  logic [3:0]  sel [3];
  logic        we  [3];
  logic        cyc [3];
  logic        stb [3];
  logic [31:0] dat_w [3];
  logic        ack_w [3];

  int cyc_n = 0;
  int n_tests = 0;
  int n_fail = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  wb_sram_slave #(.ADDR_BITS(AB), .WAIT_STATES(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .adr_i(adr[0]), .dat_i(dat[0]), .sel_i(sel[0]),
    .we_i(we[0]), .cyc_i(cyc[0]), .stb_i(stb[0]), .dat_o(dat_w[0]), .ack_o(ack_w[0]));
  wb_sram_slave #(.ADDR_BITS(AB), .WAIT_STATES(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .adr_i(adr[1]), .dat_i(dat[1]), .sel_i(sel[1]),
    .we_i(we[1]), .cyc_i(cyc[1]), .stb_i(stb[1]), .dat_o(dat_w[1]), .ack_o(ack_w[1]));
  wb_sram_slave #(.ADDR_BITS(AB), .WAIT_STATES(3)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .adr_i(adr[2]), .dat_i(dat[2]), .sel_i(sel[2]),
    .we_i(we[2]), .cyc_i(cyc[2]), .stb_i(stb[2]), .dat_o(dat_w[2]), .ack_o(ack_w[2]));

  function automatic int ws_of(input int i);
    case (i)
      0:       return 0;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic in_rng(input logic [29:0] a);
    return (a >> AB) == 30'd0;
  endfunction

  // Model: a transfer is tracked by its age in edges since capture.
  logic        m_busy [3];
  int          m_k    [3];
  logic [29:0] m_adr  [3];
  logic [31:0] m_dat  [3];
  logic [3:0]  m_sel  [3];
  logic        m_we   [3];
  logic [31:0] m_mem  [3][1024];
  logic        exp_ack [3];
  logic [31:0] exp_dat [3];

  logic        a_go  [3];
  logic        a_we  [3];
  logic [29:0] a_adr [3];
  logic [31:0] a_dat [3];
  logic [3:0]  a_sel [3];

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      a_go[i]  = 1'b0;
      a_we[i]  = we[i];
      a_adr[i] = adr[i];
      a_dat[i] = dat[i];
      a_sel[i] = sel[i];
      if (!m_busy[i]) begin
        a_go[i] = cyc[i] && stb[i] && (ws_of(i) == 0);
      end else begin
        a_we[i]  = m_we[i];
        a_adr[i] = m_adr[i];
        a_dat[i] = m_dat[i];
        a_sel[i] = m_sel[i];
        a_go[i]  = cyc[i] && stb[i] && (m_k[i] + 1 == ws_of(i));
      end
    end
  end

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_busy[i]  <= 1'b0;
        m_k[i]     <= 0;
        exp_ack[i] <= 1'b0;
        exp_dat[i] <= 32'h0;
      end else begin
        exp_ack[i] <= a_go[i];
        if (a_go[i]) begin
          if (in_rng(a_adr[i])) begin
            if (a_we[i]) m_mem[i][a_adr[i][AB-1:0]] <= merge(m_mem[i][a_adr[i][AB-1:0]], a_dat[i], a_sel[i]);
            else         exp_dat[i] <= m_mem[i][a_adr[i][AB-1:0]];
          end else if (!a_we[i]) begin
            exp_dat[i] <= 32'h0;
          end
        end
        if (!m_busy[i]) begin
          if (cyc[i] && stb[i]) begin
            m_busy[i] <= 1'b1;
            m_k[i]    <= 0;
            m_adr[i]  <= adr[i];
            m_dat[i]  <= dat[i];
            m_sel[i]  <= sel[i];
            m_we[i]   <= we[i];
          end
        end else if (m_k[i] >= ws_of(i) || !(cyc[i] && stb[i])) begin
          m_busy[i] <= 1'b0;
        end else begin
          m_k[i] <= m_k[i] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (ack_w[i] !== exp_ack[i]) begin
        n_fail++;
        $display("FAIL ack[%0d] cycle %0d: got %b want %b", i, cyc_n, ack_w[i], exp_ack[i]);
      end
      n_tests++;
      if (dat_w[i] !== exp_dat[i]) begin
        n_fail++;
        $display("FAIL dat_o[%0d] cycle %0d: got %h want %h", i, cyc_n, dat_w[i], exp_dat[i]);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Drives one request and returns the ack edge count relative to capture.
  task automatic xfer(input int i, input logic w, input logic [29:0] a, input logic [31:0] d,
                      input logic [3:0] s, output int lat, output int ack_at);
    int req_edge;
    @(posedge clk);
    #2;
    cyc[i] = 1'b1; stb[i] = 1'b1; we[i] = w; adr[i] = a; dat[i] = d; sel[i] = s;
    req_edge = cyc_n + 1;
    ack_at = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ack_w[i] === 1'b1) begin
        ack_at = cyc_n;
        break;
      end
    end
    lat = (ack_at < 0) ? -1 : ack_at - req_edge;
    if (ack_at < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL ack_timeout[%0d]: got no ack want ack at adr %h", i, a);
    end
  endtask

  task automatic idle(input int i);
    @(posedge clk);
    #2;
    cyc[i] = 1'b0; stb[i] = 1'b0;
  endtask

  task automatic count_acks(input int i, input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (ack_w[i] === 1'b1) n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, at, prev, n;
    for (int i = 0; i < 3; i++) begin
      cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0;
      adr[i] = 30'd0; dat[i] = 32'd0; sel[i] = 4'd0;
    end
    repeat (3) @(posedge clk);
    #2;
    check("reset_ack", 32'(ack_w[1]), 32'h0);
    check("reset_dat", dat_w[1], 32'h0);
    rst = 1'b0;
    count_acks(1, 20, n);
    check("idle_no_ack", n, 0);

    // Latency and single-cycle ack with one wait state
    xfer(1, 1'b1, 30'd5, 32'hDEADBEEF, 4'hF, lat, at);
    check("wr_latency", lat, 1);
    idle(1);
    @(negedge clk);
    check("ack_width", 32'(ack_w[1]), 32'h0);
    xfer(1, 1'b0, 30'd5, 32'h0, 4'hF, lat, at);
    check("rd_latency", lat, 1);
    check("rd_5", dat_w[1], 32'hDEADBEEF);
    idle(1);

    // Byte lanes and an empty byte select
    xfer(1, 1'b1, 30'd5, 32'h11223344, 4'b0101, lat, at); idle(1);
    xfer(1, 1'b0, 30'd5, 32'h0, 4'h0, lat, at); idle(1);
    check("byte_sel", dat_w[1], 32'hDE22BE44);
    xfer(1, 1'b1, 30'd5, 32'hFFFFFFFF, 4'h0, lat, at); idle(1);
    check("sel0_acked", lat, 1);
    xfer(1, 1'b0, 30'd5, 32'h0, 4'hF, lat, at); idle(1);
    check("sel0_unchanged", dat_w[1], 32'hDE22BE44);

    // Out of range
    xfer(1, 1'b1, 30'd0, 32'h00C0FFEE, 4'hF, lat, at); idle(1);
    xfer(1, 1'b1, 30'h400, 32'h12345678, 4'hF, lat, at); idle(1);
    check("oor_wr_acked", lat, 1);
    xfer(1, 1'b0, 30'h400, 32'h0, 4'hF, lat, at); idle(1);
    check("oor_rd_zero", dat_w[1], 32'h0);
    xfer(1, 1'b0, 30'd0, 32'h0, 4'hF, lat, at); idle(1);
    check("oor_no_alias", dat_w[1], 32'h00C0FFEE);

    // Abort with three wait states
    xfer(2, 1'b1, 30'd7, 32'hA5A50007, 4'hF, lat, at); idle(2);
    check("ws3_latency", lat, 3);
    @(posedge clk); #2;
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = 30'd7; dat[2] = 32'hCAFEF00D; sel[2] = 4'hF;
    @(posedge clk); #2;
    stb[2] = 1'b0; cyc[2] = 1'b0;
    count_acks(2, 12, n);
    check("abort_no_ack", n, 0);
    xfer(2, 1'b0, 30'd7, 32'h0, 4'hF, lat, at); idle(2);
    check("abort_no_write", dat_w[2], 32'hA5A50007);

    // Reset while waiting loses the pending write
    @(posedge clk); #2;
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = 30'd7; dat[2] = 32'h77777777; sel[2] = 4'hF;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("wait_rst_ack", 32'(ack_w[2]), 32'h0);
    @(posedge clk); #2;
    rst = 1'b0; cyc[2] = 1'b0; stb[2] = 1'b0;
    xfer(2, 1'b0, 30'd7, 32'h0, 4'hF, lat, at); idle(2);
    check("wait_rst_lost", dat_w[2], 32'hA5A50007);

    // Streaming with zero wait states
    for (int k = 0; k < 8; k++) xfer(0, 1'b1, 30'(k), 32'h10000000 | (k << 8) | k, 4'hF, lat, at);
    idle(0);
    prev = 0;
    for (int k = 0; k < 8; k++) begin
      xfer(0, 1'b0, 30'(k), 32'h0, 4'hF, lat, at);
      check($sformatf("stream_dat%0d", k), dat_w[0], 32'h10000000 | (k << 8) | k);
      if (k > 0) check($sformatf("stream_period%0d", k), at - prev, 2);
      prev = at;
    end
    idle(0);

    // Streaming again with reset pulsed during the fourth transfer
    for (int k = 0; k < 8; k++) begin
      if (k == 3) begin
        @(posedge clk); #2;
        adr[0] = 30'd3;
        #1;
        rst = 1'b1;
        #1;
        check("stream_rst_ack", 32'(ack_w[0]), 32'h0);
        check("stream_rst_dat", dat_w[0], 32'h0);
        @(posedge clk); #2;
        rst = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0;
        count_acks(0, 3, n);
        check("stream_rst_no_ack", n, 0);
      end else begin
        xfer(0, 1'b0, 30'(k), 32'h0, 4'hF, lat, at);
        check($sformatf("stream2_dat%0d", k), dat_w[0], 32'h10000000 | (k << 8) | k);
        if (k > 4 || k == 1 || k == 2) check($sformatf("stream2_period%0d", k), at - prev, 2);
        prev = at;
      end
    end
    idle(0);

    // Reset during ACK: ack and dat_o drop at once, committed write stays
    xfer(1, 1'b0, 30'd0, 32'h0, 4'hF, lat, at); idle(1);
    xfer(1, 1'b1, 30'd9, 32'h55AA55AA, 4'hF, lat, at);
    check("pre_rst_dat", dat_w[1], 32'h00C0FFEE);
    #1;
    rst = 1'b1;
    #1;
    check("ack_rst_ack", 32'(ack_w[1]), 32'h0);
    check("ack_rst_dat", dat_w[1], 32'h0);
    @(posedge clk); #2;
    rst = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0;
    xfer(1, 1'b0, 30'd9, 32'h0, 4'hF, lat, at); idle(1);
    check("committed_write", dat_w[1], 32'h55AA55AA);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
